key_74165_reader: RTL and testbench
===================================

Name: key_74165_reader

Overview:
- Periodically scans a chain of 74HC165 parallel-in/serial-out shift registers (board keys/DIP switches) and presents a debounced parallel word to user logic.
- Input-side counterpart of the 74HC595 LED output path; shares the same board-level serial clock/latch style.
- Generates SH/LD, CLK and CLK INH for the chain, samples QH, and debounces over consecutive scans.

Parameters:
DATA_WIDTH, 8, total bits in the chain (8 per 74HC165); >= 2
HALF_CYC, 4, clk cycles per serial-clock half period; >= 3
SCAN_GAP, 50000, idle clk cycles between the end of one scan and the start of the next; >= 1
DEBOUNCE_SCANS, 4, consecutive identical scans required before key_data updates; >= 1

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
key165_din  in  1  QH serial output of the last 74HC165 in the chain
key165_clk  out  1  shift clock; chain shifts on rising edge
key165_load_n  out  1  SH/LD; low = parallel load
key165_inh  out  1  CLK INH; high = clock inhibited
raw_data  out  DATA_WIDTH  undebounced result of the last completed scan
scan_done  out  1  one-cycle pulse, raw_data valid
key_data  out  DATA_WIDTH  debounced key word
key_update  out  1  one-cycle pulse when key_data changes

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset values: key165_clk=0, key165_load_n=1, key165_inh=1, raw_data=all ones, scan_done=0, key_data=all ones (pull-up idle), key_update=0. prev_raw=all ones, stable_cnt=0. FSM=IDLE with its gap counter preloaded so LOAD starts on the first clk edge after rst_n deasserts.
- key165_din passes a 2-flop synchronizer before use. This is why HALF_CYC >= 3.
- FSM states:
  - IDLE: clk=0, load_n=1, inh=1. Counts SCAN_GAP cycles, then -> LOAD.
  - LOAD: load_n=0, inh=1, clk=0, for 2*HALF_CYC cycles -> SETTLE.
  - SETTLE: load_n=1, inh=0, clk=0, for HALF_CYC cycles -> SHIFT, with bit_cnt=0.
  - SHIFT: per bit, clk=0 for HALF_CYC cycles, then clk=1 for HALF_CYC cycles.
    - On the last cycle of each low phase, shift the synchronized din into the shift register: sreg <= {sreg[W-2:0], din}.
    - After the high phase of bit DATA_WIDTH-1 -> DONE.
  - DONE (1 cycle): clk=0, inh=1. raw_data <= sreg and scan_done=1 in this cycle, raw_data visible from the next cycle. Debounce evaluates, then -> IDLE.
- Bit order: the first sampled bit is the H input of the chip nearest the FPGA and lands in raw_data[DATA_WIDTH-1]. The last sampled bit lands in raw_data[0].
- Scan length = 3*HALF_CYC + 2*HALF_CYC*DATA_WIDTH + 1 cycles (77 at defaults).
- Debounce, evaluated in DONE against the new sreg value:
  - If sreg != prev_raw: stable_cnt <= 1.
  - Otherwise stable_cnt <= min(stable_cnt+1, DEBOUNCE_SCANS).
  - prev_raw <= sreg.
  - If the new stable_cnt == DEBOUNCE_SCANS and sreg != key_data: key_data <= sreg, and key_update pulses for one cycle, in the cycle after DONE.
  - DEBOUNCE_SCANS=1 means key_data follows every changed scan.
  - stable_cnt saturates and never wraps.
- key_update never fires when a stable value equals the current key_data, including the all-ones reset value.
- Reset mid-scan: all outputs return to reset values immediately. The partial sreg is discarded. A fresh scan starts after release.
- Outputs are registered; no combinational path from key165_din to any output.

Test Plan:
- Reset release, din driven from an 8-bit 74HC165 model with inputs 8'hFF -> load_n low 8 cycles starting on the first edge after release; 8 clk pulses of 4-high/4-low; scan_done at cycle 77; raw_data=8'hFF; no key_update.
- Model inputs 8'hA5 static -> raw_data=8'hA5 after each scan; key_data=8'hA5 and a single key_update pulse only after the 4th scan; none afterwards.
- Bounce: inputs alternate 8'hFE/8'hFF on successive scans for 10 scans, then hold 8'hFE -> key_data stays 8'hFF until the 4th consecutive 8'hFE scan, then becomes 8'hFE with one key_update.
- Bit order: model 16-bit chain (DATA_WIDTH=16) with near chip 8'h80 and far chip 8'h01 -> raw_data=16'h8001; 16 serial pulses per scan.
- Assert rst_n low during bit 3 of SHIFT -> key165_clk=0, load_n=1, inh=1, key_data=all ones at once; no scan_done for the aborted scan; a full new scan completes 77 cycles after release.
- SCAN_GAP=10: measure load_n falling edges -> spacing = 77+10 cycles; scan_done once per scan.

Source files
------------

// File: rtl/key_74165_reader.sv
// Periodic scanner for a 74HC165 shift-register chain: drives SH/LD, CLK and CLK INH,
// samples QH through a synchronizer and debounces the parallel key word over several scans.
module key_74165_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int HALF_CYC       = 4,
  parameter int SCAN_GAP       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key165_din,
  output logic                  key165_clk,
  output logic                  key165_load_n,
  output logic                  key165_inh,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  scan_done,
  output logic [DATA_WIDTH-1:0] key_data,
  output logic                  key_update
);

  localparam int CNT_MAX = (SCAN_GAP > 2 * HALF_CYC) ? SCAN_GAP : 2 * HALF_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_WIDTH);
  localparam int STB_W   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SCAN_GAP - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(2 * HALF_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [STB_W-1:0] STB_MAX   = STB_W'(DEBOUNCE_SCANS);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHIFT, DONE} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_next;
  logic                    high, high_next;
  logic                    shift_en;
  logic                    din_meta, din_sync;
  logic [DATA_WIDTH-1:0]   sreg;
  logic [DATA_WIDTH-1:0]   prev_raw;
  logic [STB_W-1:0]        stable_cnt, stable_new;
  logic                    accept;
  logic                    sclk_next, load_n_next, inh_next, done_next;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    bit_cnt_next = bit_cnt;
    high_next    = high;
    shift_en     = 1'b0;
    unique case (state)
      IDLE: if (cnt == GAP_LAST) begin
        state_next = LOAD;
        cnt_next   = '0;
      end
      LOAD: if (cnt == LOAD_LAST) begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: if (cnt == HALF_LAST) begin
        state_next   = SHIFT;
        cnt_next     = '0;
        bit_cnt_next = '0;
        high_next    = 1'b0;
      end
      SHIFT: if (cnt == HALF_LAST) begin
        cnt_next = '0;
        if (!high) begin
          // QH is captured at the end of the low phase, just before the rising shift edge
          shift_en  = 1'b1;
          high_next = 1'b1;
        end else if (bit_cnt == BIT_LAST) begin
          state_next = DONE;
          high_next  = 1'b0;
        end else begin
          bit_cnt_next = bit_cnt + BIT_W'(1);
          high_next    = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Chain control lines are registered from the next state so they line up with it
    sclk_next   = (state_next == SHIFT) && high_next;
    load_n_next = (state_next != LOAD);
    inh_next    = !((state_next == SETTLE) || (state_next == SHIFT));
    done_next   = (state_next == DONE);
  end

  always_comb begin
    if (sreg != prev_raw)
      stable_new = STB_W'(1);
    else if (stable_cnt == STB_MAX)
      stable_new = STB_MAX;
    else
      stable_new = stable_cnt + STB_W'(1);
    accept = (stable_new == STB_MAX) && (sreg != key_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= GAP_LAST;
      bit_cnt       <= '0;
      high          <= 1'b0;
      din_meta      <= 1'b1;
      din_sync      <= 1'b1;
      sreg          <= '1;
      prev_raw      <= '1;
      stable_cnt    <= '0;
      key165_clk    <= 1'b0;
      key165_load_n <= 1'b1;
      key165_inh    <= 1'b1;
      raw_data      <= '1;
      scan_done     <= 1'b0;
      key_data      <= '1;
      key_update    <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bit_cnt       <= bit_cnt_next;
      high          <= high_next;
      din_meta      <= key165_din;
      din_sync      <= din_meta;
      key165_clk    <= sclk_next;
      key165_load_n <= load_n_next;
      key165_inh    <= inh_next;
      scan_done     <= done_next;
      if (shift_en)
        sreg <= {sreg[DATA_WIDTH-2:0], din_sync};
      if (state == DONE) begin
        raw_data   <= sreg;
        prev_raw   <= sreg;
        stable_cnt <= stable_new;
        key_update <= accept;
        if (accept)
          key_data <= sreg;
      end else begin
        key_update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_74165_reader.sv
// Bench for key_74165_reader: behavioural 74HC165 chains feed two readers (8 and 16 bits)
// and a queue-based debounce model predicts key_data / key_update per scan.
module tb_key_74165_reader;

  localparam int GAP  = 10;
  localparam int DEB  = 4;
  localparam int SCAN8  = 3 * 4 + 2 * 4 * 8 + 1;
  localparam int SCAN16 = 3 * 4 + 2 * 4 * 16 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        din8, sclk8, load8, inh8, done8, upd8;
  logic [7:0]  raw8, key8;
  logic        din16, sclk16, load16, inh16, done16, upd16;
  logic [15:0] raw16, key16;

  key_74165_reader #(.DATA_WIDTH(8), .HALF_CYC(4), .SCAN_GAP(GAP), .DEBOUNCE_SCANS(DEB)) dut8 (
    .clk(clk), .rst_n(rst_n), .key165_din(din8), .key165_clk(sclk8),
    .key165_load_n(load8), .key165_inh(inh8), .raw_data(raw8), .scan_done(done8),
    .key_data(key8), .key_update(upd8));

  key_74165_reader #(.DATA_WIDTH(16), .HALF_CYC(4), .SCAN_GAP(GAP), .DEBOUNCE_SCANS(DEB)) dut16 (
    .clk(clk), .rst_n(rst_n), .key165_din(din16), .key165_clk(sclk16),
    .key165_load_n(load16), .key165_inh(inh16), .raw_data(raw16), .scan_done(done16),
    .key_data(key16), .key_update(upd16));

  // 74HC165 chain models: parallel load while SH/LD low, shift on rising CLK when not inhibited
  logic [7:0]  par8 = 8'hFF, chain8 = 8'hFF;
  logic [15:0] par16 = 16'h8001, chain16 = 16'hFFFF;
  logic        psclk8 = 1'b0, psclk16 = 1'b0;

  always @(posedge clk) begin
    psclk8 <= sclk8;
    if (!load8) chain8 <= par8;
    else if (sclk8 && !psclk8 && !inh8) chain8 <= {chain8[6:0], 1'b1};
    psclk16 <= sclk16;
    if (!load16) chain16 <= par16;
    else if (sclk16 && !psclk16 && !inh16) chain16 <= {chain16[14:0], 1'b1};
  end
  assign din8  = chain8[7];
  assign din16 = chain16[15];

  int n_checks = 0;
  int n_fail   = 0;
  int spurious = 0;
  int upd_seen = 0;

  // Debounce reference: last DEB scans kept in a queue
  logic [7:0] hist[$];
  logic [7:0] key_ref = 8'hFF;

  task automatic ref_reset();
    hist.delete();
    key_ref = 8'hFF;
  endtask

  task automatic ref_scan(input logic [7:0] v, output logic upd);
    logic same;
    hist.push_back(v);
    if (hist.size() > DEB) void'(hist.pop_front());
    same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != v) same = 1'b0;
    upd = same && (v != key_ref);
    if (upd) key_ref = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan8(input logic [7:0] v);
    logic got, exp_upd;
    got = 1'b0;
    par8 = v;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (upd8) spurious++;
      if (done8) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL scan8_timeout: no scan_done, required one within 400 cycles");
    end
    ref_scan(v, exp_upd);
    tick();
    n_checks++;
    if (raw8 !== v) begin
      n_fail++;
      $display("FAIL scan8_raw: got %h required %h", raw8, v);
    end
    n_checks++;
    if (upd8 !== exp_upd) begin
      n_fail++;
      $display("FAIL scan8_update: got %b required %b (value %h)", upd8, exp_upd, v);
    end
    n_checks++;
    if (key8 !== key_ref) begin
      n_fail++;
      $display("FAIL scan8_key: got %h required %h", key8, key_ref);
    end
    if (upd8) upd_seen++;
    $display("scan8 in=%h raw=%h key=%h upd=%b", v, raw8, key8, upd8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({sclk8, load8, inh8, done8, upd8} !== 5'b01100) begin
      n_fail++;
      $display("FAIL reset_ctrl: clk/load_n/inh/done/upd got %b required 01100",
               {sclk8, load8, inh8, done8, upd8});
    end
    n_checks++;
    if (raw8 !== 8'hFF || key8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_data: raw %h key %h required ff ff", raw8, key8);
    end
    $display("reset: raw=%h key=%h load_n=%b inh=%b", raw8, key8, load8, inh8);
  endtask

  task automatic test_first_scan();
    int first_load, load_cnt, pulses, high_cnt, done_cyc;
    logic prev_clk;
    first_load = -1; load_cnt = 0; pulses = 0; high_cnt = 0; done_cyc = -1;
    prev_clk = 1'b0;
    par8 = 8'hFF;
    ref_reset();
    rst_n = 1'b1;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      tick();
      if (!load8) begin
        load_cnt++;
        if (first_load < 0) first_load = c;
      end
      if (sclk8) high_cnt++;
      if (sclk8 && !prev_clk) pulses++;
      prev_clk = sclk8;
      if (upd8) spurious++;
      if (done8) done_cyc = c;
    end
    n_checks++;
    if (first_load !== 1 || load_cnt !== 8) begin
      n_fail++;
      $display("FAIL first_load: start %0d len %0d required 1 8", first_load, load_cnt);
    end
    n_checks++;
    if (pulses !== 8 || high_cnt !== 32) begin
      n_fail++;
      $display("FAIL first_pulses: pulses %0d high %0d required 8 32", pulses, high_cnt);
    end
    n_checks++;
    if (done_cyc !== SCAN8) begin
      n_fail++;
      $display("FAIL first_done_cycle: got %0d required %0d", done_cyc, SCAN8);
    end
    tick();
    n_checks++;
    if (raw8 !== 8'hFF || upd8 !== 1'b0 || key8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL first_result: raw %h upd %b key %h required ff 0 ff", raw8, upd8, key8);
    end
    begin
      logic u;
      ref_scan(8'hFF, u);
    end
    $display("first scan: load@%0d len=%0d pulses=%0d done@%0d raw=%h", first_load, load_cnt,
             pulses, done_cyc, raw8);
  endtask

  task automatic test_bounce();
    spurious = 0;
    upd_seen = 0;
    for (int s = 0; s < 10; s++) run_scan8((s % 2 == 0) ? 8'hFE : 8'hFF);
    for (int s = 0; s < 5; s++) run_scan8(8'hFE);
    n_checks++;
    if (upd_seen !== 1 || spurious !== 0) begin
      n_fail++;
      $display("FAIL bounce_updates: got %0d (+%0d stray) required 1", upd_seen, spurious);
    end
  endtask

  task automatic test_static();
    spurious = 0;
    upd_seen = 0;
    for (int s = 0; s < 6; s++) run_scan8(8'hA5);
    n_checks++;
    if (upd_seen !== 1 || spurious !== 0) begin
      n_fail++;
      $display("FAIL static_updates: got %0d (+%0d stray) required 1", upd_seen, spurious);
    end
  endtask

  task automatic test_reset_mid_scan();
    int done_cyc, dones_early;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (!load8) got = 1'b1;
    end
    // now in LOAD cycle 1; cycle 42 is the high phase of bit 3
    for (int i = 0; i < 41; i++) tick();
    n_checks++;
    if (!got || sclk8 !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_setup: load seen %b clk %b required 1 1", got, sclk8);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sclk8, load8, inh8, done8} !== 4'b0110 || key8 !== 8'hFF || raw8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL midscan_async: ctrl %b key %h raw %h required 0110 ff ff",
               {sclk8, load8, inh8, done8}, key8, raw8);
    end
    dones_early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done8) dones_early++;
    end
    ref_reset();
    par8 = 8'h3C;
    rst_n = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      tick();
      if (done8) done_cyc = c;
    end
    n_checks++;
    if (done_cyc !== SCAN8 || dones_early !== 0) begin
      n_fail++;
      $display("FAIL midscan_restart: done@%0d early %0d required %0d 0", done_cyc, dones_early,
               SCAN8);
    end
    tick();
    begin
      logic u;
      ref_scan(8'h3C, u);
    end
    n_checks++;
    if (raw8 !== 8'h3C || key8 !== key_ref) begin
      n_fail++;
      $display("FAIL midscan_result: raw %h key %h required 3c %h", raw8, key8, key_ref);
    end
    $display("reset mid-scan: restart done@%0d raw=%h key=%h", done_cyc, raw8, key8);
  endtask

  task automatic test_random();
    logic [7:0] v;
    spurious = 0;
    for (int g = 0; g < 8; g++) begin
      v = 8'($urandom_range(0, 255));
      if (g % 3 == 2) v = key_ref;
      for (int r = $urandom_range(1, 5); r > 0; r--) run_scan8(v);
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL random_stray_updates: got %0d required 0", spurious);
    end
  endtask

  task automatic test_gap();
    int t, fall1, fall2, dones;
    logic prev;
    fall1 = -1; fall2 = -1; dones = 0;
    prev = load8;
    t = 0;
    for (int i = 0; i < 400 && fall2 < 0; i++) begin
      tick();
      t++;
      if (prev && !load8) begin
        if (fall1 < 0) fall1 = t;
        else fall2 = t;
      end
      if (fall1 >= 0 && done8) dones++;
      prev = load8;
    end
    n_checks++;
    if (fall2 - fall1 !== SCAN8 + GAP || dones !== 1) begin
      n_fail++;
      $display("FAIL gap_spacing: spacing %0d dones %0d required %0d 1", fall2 - fall1, dones,
               SCAN8 + GAP);
    end
    $display("gap: load_n falling spacing=%0d scan_done=%0d", fall2 - fall1, dones);
  endtask

  task automatic run_scan16(input logic [15:0] v, output logic got);
    got = 1'b0;
    par16 = v;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (done16) got = 1'b1;
    end
    tick();
  endtask

  task automatic test_bit_order();
    int t, done_cyc, pulses;
    logic got, prev_clk;
    logic [15:0] v, old;
    got = 1'b0;
    par16 = 16'h8001;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (done16) got = 1'b1;
    end
    for (int i = 0; i < 400 && load16; i++) tick();
    t = 1; pulses = 0; done_cyc = -1; prev_clk = sclk16;
    for (int i = 0; i < 400 && done_cyc < 0; i++) begin
      tick();
      t++;
      if (sclk16 && !prev_clk) pulses++;
      prev_clk = sclk16;
      if (done16) done_cyc = t;
    end
    tick();
    n_checks++;
    if (raw16 !== 16'h8001 || pulses !== 16 || done_cyc !== SCAN16) begin
      n_fail++;
      $display("FAIL bit_order: raw %h pulses %0d done@%0d required 8001 16 %0d", raw16, pulses,
               done_cyc, SCAN16);
    end
    $display("scan16 raw=%h pulses=%0d done@%0d", raw16, pulses, done_cyc);
    for (int g = 0; g < 3; g++) begin
      old = key16;
      do v = 16'($urandom_range(0, 65535)); while (v == old);
      for (int s = 1; s <= DEB; s++) begin
        run_scan16(v, got);
        n_checks++;
        if (!got || raw16 !== v) begin
          n_fail++;
          $display("FAIL scan16_raw: got %h (done %b) required %h", raw16, got, v);
        end
        n_checks++;
        if (key16 !== ((s == DEB) ? v : old) || upd16 !== (s == DEB)) begin
          n_fail++;
          $display("FAIL scan16_key: key %h upd %b required %h %b", key16, upd16,
                   (s == DEB) ? v : old, s == DEB);
        end
        $display("scan16 in=%h raw=%h key=%h upd=%b", v, raw16, key16, upd16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_bounce();
    test_static();
    test_reset_mid_scan();
    test_random();
    test_gap();
    test_bit_order();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
